// File: rtl/ad9851gfsk_axil_regs.sv
// AXI4-Lite register file for the AD9851 GFSK core: control, mark FTW, space FTW and aux.
// Optional macro AD9851_AXIL_DECERR_EN turns upper address bits into SLVERR decoding.
module ad9851gfsk_axil_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [31:0]                     ctrl_o,
   output logic [31:0]                     ftw_mark_o,
   output logic [31:0]                     ftw_space_o,
   output logic [31:0]                     aux_o,
   output logic [3:0]                      reg_wr_stb_o
);

   localparam int NumBytes = C_S_AXI_DATA_WIDTH / 8;

   typedef enum logic {W_IDLE, W_RESP} wState_t;
   typedef enum logic {R_IDLE, R_DATA} rState_t;

   wState_t                          wState_q;
   rState_t                          rState_q;
   logic                             awReady_q, wReady_q, arReady_q;
   logic                             awHave_q, wHave_q;
   logic [C_S_AXI_ADDR_WIDTH-1:0]    awAddr_q;
   logic [C_S_AXI_DATA_WIDTH-1:0]    wData_q;
   logic [NumBytes-1:0]              wStrb_q;
   logic                             bValid_q, rValid_q;
   logic [1:0]                       bResp_q, rResp_q;
   logic [C_S_AXI_DATA_WIDTH-1:0]    rData_q;
   logic [C_S_AXI_DATA_WIDTH-1:0]    regs_q [4];
   logic [C_S_AXI_DATA_WIDTH-1:0]    regs_d [4];
   logic [3:0]                       wrStb_q, wrStb_d;

   logic                             awHs, wHs, arHs, commit;
   logic [C_S_AXI_ADDR_WIDTH-1:0]    awAddrEff;
   logic [C_S_AXI_DATA_WIDTH-1:0]    wDataEff;
   logic [NumBytes-1:0]              wStrbEff;
   logic [1:0]                       wIdx, rIdx;
   logic                             wOor, rOor;

   assign awHs = S_AXI_AWVALID && awReady_q;
   assign wHs  = S_AXI_WVALID  && wReady_q;
   assign arHs = S_AXI_ARVALID && arReady_q;

   // A channel that already handshook is served from its holding register.
   assign awAddrEff = awHave_q ? awAddr_q : S_AXI_AWADDR;
   assign wDataEff  = wHave_q  ? wData_q  : S_AXI_WDATA;
   assign wStrbEff  = wHave_q  ? wStrb_q  : S_AXI_WSTRB;
   assign commit    = (wState_q == W_IDLE) && (awHave_q || awHs) && (wHave_q || wHs);
   assign wIdx      = awAddrEff[3:2];
   assign rIdx      = S_AXI_ARADDR[3:2];

`ifdef AD9851_AXIL_DECERR_EN
   assign wOor = (awAddrEff >> 4) != '0;
   assign rOor = (S_AXI_ARADDR >> 4) != '0;
`else
   assign wOor = 1'b0;
   assign rOor = 1'b0;
`endif

   always_comb begin
      regs_d  = regs_q;
      wrStb_d = 4'b0000;
      if (commit && !wOor) begin
         wrStb_d[wIdx] = 1'b1;
         for (int b = 0; b < NumBytes; b++) begin
            if (wStrbEff[b]) begin
               regs_d[wIdx][8*b +: 8] = wDataEff[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         wState_q  <= W_IDLE;
         awReady_q <= 1'b0;
         wReady_q  <= 1'b0;
         awHave_q  <= 1'b0;
         wHave_q   <= 1'b0;
         awAddr_q  <= '0;
         wData_q   <= '0;
         wStrb_q   <= '0;
         bValid_q  <= 1'b0;
         bResp_q   <= 2'b00;
         wrStb_q   <= 4'b0000;
         for (int i = 0; i < 4; i++) regs_q[i] <= '0;
      end else begin
         regs_q  <= regs_d;
         wrStb_q <= wrStb_d;
         case (wState_q)
            W_IDLE: begin
               if (commit) begin
                  awReady_q <= 1'b0;
                  wReady_q  <= 1'b0;
                  awHave_q  <= 1'b0;
                  wHave_q   <= 1'b0;
                  bValid_q  <= 1'b1;
                  bResp_q   <= wOor ? 2'b10 : 2'b00;
                  wState_q  <= W_RESP;
               end else begin
                  if (awHs) begin
                     awAddr_q  <= S_AXI_AWADDR;
                     awHave_q  <= 1'b1;
                     awReady_q <= 1'b0;
                  end else if (!awHave_q) begin
                     awReady_q <= 1'b1;
                  end
                  if (wHs) begin
                     wData_q  <= S_AXI_WDATA;
                     wStrb_q  <= S_AXI_WSTRB;
                     wHave_q  <= 1'b1;
                     wReady_q <= 1'b0;
                  end else if (!wHave_q) begin
                     wReady_q <= 1'b1;
                  end
               end
            end
            W_RESP: begin
               if (S_AXI_BREADY) begin
                  bValid_q  <= 1'b0;
                  bResp_q   <= 2'b00;
                  awReady_q <= 1'b1;
                  wReady_q  <= 1'b1;
                  wState_q  <= W_IDLE;
               end
            end
            default: wState_q <= W_IDLE;
         endcase
      end
   end

   // Reads sample regs_q, so a read landing on a commit edge sees the old value.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         rState_q  <= R_IDLE;
         arReady_q <= 1'b0;
         rValid_q  <= 1'b0;
         rResp_q   <= 2'b00;
         rData_q   <= '0;
      end else begin
         case (rState_q)
            R_IDLE: begin
               if (arHs) begin
                  arReady_q <= 1'b0;
                  rValid_q  <= 1'b1;
                  rData_q   <= rOor ? '0 : regs_q[rIdx];
                  rResp_q   <= rOor ? 2'b10 : 2'b00;
                  rState_q  <= R_DATA;
               end else begin
                  arReady_q <= 1'b1;
               end
            end
            R_DATA: begin
               if (S_AXI_RREADY) begin
                  rValid_q  <= 1'b0;
                  arReady_q <= 1'b1;
                  rState_q  <= R_IDLE;
               end
            end
            default: rState_q <= R_IDLE;
         endcase
      end
   end

   logic unusedOk;
   assign unusedOk = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR, awAddrEff};

   assign S_AXI_AWREADY = awReady_q;
   assign S_AXI_WREADY  = wReady_q;
   assign S_AXI_BVALID  = bValid_q;
   assign S_AXI_BRESP   = bResp_q;
   assign S_AXI_ARREADY = arReady_q;
   assign S_AXI_RVALID  = rValid_q;
   assign S_AXI_RRESP   = rResp_q;
   assign S_AXI_RDATA   = rData_q;
   assign ctrl_o        = regs_q[0];
   assign ftw_mark_o    = regs_q[1];
   assign ftw_space_o   = regs_q[2];
   assign aux_o         = regs_q[3];
   assign reg_wr_stb_o  = wrStb_q;

endmodule

// File: tb/tb_ad9851gfsk_axil_regs.sv
// Directed bench for ad9851gfsk_axil_regs: handshakes, byte strobes, backpressure,
// read/write collision and asynchronous reset.
module tb_ad9851gfsk_axil_regs;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic [3:0]  awAddr = '0;
   logic [2:0]  awProt = '0;
   logic        awValid = 1'b0;
   logic        awReady;
   logic [31:0] wData = '0;
   logic [3:0]  wStrb = '0;
   logic        wValid = 1'b0;
   logic        wReady;
   logic [1:0]  bResp;
   logic        bValid;
   logic        bReady = 1'b0;
   logic [3:0]  arAddr = '0;
   logic [2:0]  arProt = '0;
   logic        arValid = 1'b0;
   logic        arReady;
   logic [31:0] rData;
   logic [1:0]  rResp;
   logic        rValid;
   logic        rReady = 1'b0;
   logic [31:0] ctrl, ftwMark, ftwSpace, aux;
   logic [3:0]  wrStb;

   int testsRun = 0;
   int testsFailed = 0;

   always #5 clk = ~clk;

   ad9851gfsk_axil_regs dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstN),
      .S_AXI_AWADDR(awAddr), .S_AXI_AWPROT(awProt), .S_AXI_AWVALID(awValid), .S_AXI_AWREADY(awReady),
      .S_AXI_WDATA(wData), .S_AXI_WSTRB(wStrb), .S_AXI_WVALID(wValid), .S_AXI_WREADY(wReady),
      .S_AXI_BRESP(bResp), .S_AXI_BVALID(bValid), .S_AXI_BREADY(bReady),
      .S_AXI_ARADDR(arAddr), .S_AXI_ARPROT(arProt), .S_AXI_ARVALID(arValid), .S_AXI_ARREADY(arReady),
      .S_AXI_RDATA(rData), .S_AXI_RRESP(rResp), .S_AXI_RVALID(rValid), .S_AXI_RREADY(rReady),
      .ctrl_o(ctrl), .ftw_mark_o(ftwMark), .ftw_space_o(ftwSpace), .aux_o(aux),
      .reg_wr_stb_o(wrStb)
   );

   // Every task starts and ends 1 time unit after a rising edge.
   task automatic stepClk();
      @(posedge clk);
      #1;
   endtask

   task automatic doWrite(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] respSeen, output logic [3:0] stbSeen);
      bit awDone = 0, wDone = 0, awHs, wHs, bHs;
      int n = 0;
      awAddr = addr; awValid = 1'b1;
      wData = data; wStrb = strb; wValid = 1'b1;
      while (!(awDone && wDone) && n < 20) begin
         awHs = awValid && awReady;
         wHs  = wValid && wReady;
         stepClk();
         if (awHs) begin awValid = 1'b0; awDone = 1; end
         if (wHs)  begin wValid = 1'b0;  wDone = 1;  end
         n++;
      end
      stbSeen = wrStb;
      awValid = 1'b0; wValid = 1'b0;
      if (!(awDone && wDone)) begin
         testsRun++; testsFailed++;
         $display("[TB] FAIL write_timeout addr=%h", addr);
      end
      bReady = 1'b1;
      n = 0;
      respSeen = 2'bxx;
      bHs = 0;
      while (!bHs && n < 20) begin
         bHs = bValid && bReady;
         respSeen = bResp;
         stepClk();
         n++;
      end
      bReady = 1'b0;
      if (!bHs) begin
         testsRun++; testsFailed++;
         $display("[TB] FAIL bresp_timeout addr=%h", addr);
      end
   endtask

   task automatic doRead(input logic [3:0] addr, output logic [31:0] dataSeen, output logic [1:0] respSeen);
      bit hs = 0;
      int n = 0;
      arAddr = addr; arValid = 1'b1;
      while (!hs && n < 20) begin
         hs = arValid && arReady;
         stepClk();
         n++;
      end
      arValid = 1'b0;
      if (!hs) begin
         testsRun++; testsFailed++;
         $display("[TB] FAIL ar_timeout addr=%h", addr);
      end
      rReady = 1'b1;
      hs = 0; n = 0;
      dataSeen = 'x; respSeen = 'x;
      while (!hs && n < 20) begin
         hs = rValid && rReady;
         dataSeen = rData;
         respSeen = rResp;
         stepClk();
         n++;
      end
      rReady = 1'b0;
      if (!hs) begin
         testsRun++; testsFailed++;
         $display("[TB] FAIL r_timeout addr=%h", addr);
      end
   endtask

   task automatic test_reset();
      #2;
      testsRun++;
      if ({awReady, wReady, arReady, bValid, rValid} !== 5'b0) begin
         testsFailed++; $display("[TB] FAIL reset_handshake got=%b want=00000", {awReady, wReady, arReady, bValid, rValid});
      end
      testsRun++;
      if ({ctrl, ftwMark, ftwSpace, aux} !== 128'h0) begin
         testsFailed++; $display("[TB] FAIL reset_regs got=%h want=0", {ctrl, ftwMark, ftwSpace, aux});
      end
      testsRun++;
      if ({bResp, rResp, rData, wrStb} !== 40'h0) begin
         testsFailed++; $display("[TB] FAIL reset_resp got=%h want=0", {bResp, rResp, rData, wrStb});
      end
      @(negedge clk);
      rstN = 1'b1;
      stepClk();
      testsRun++;
      if ({awReady, wReady, arReady} !== 3'b111) begin
         testsFailed++; $display("[TB] FAIL ready_after_reset got=%b want=111", {awReady, wReady, arReady});
      end
   endtask

   task automatic test_sequential();
      logic [1:0]  resp;
      logic [3:0]  stb;
      logic [31:0] d;
      for (int i = 0; i < 4; i++) begin
         doWrite(4'(i * 4), 32'(i + 1), 4'hF, resp, stb);
         testsRun++;
         if (resp !== 2'b00 || stb !== 4'(1 << i)) begin
            testsFailed++; $display("[TB] FAIL seq_write%0d got resp=%b stb=%b want resp=00 stb=%b", i, resp, stb, 4'(1 << i));
         end
      end
      for (int i = 0; i < 4; i++) begin
         doRead(4'(i * 4), d, resp);
         testsRun++;
         if (d !== 32'(i + 1) || resp !== 2'b00) begin
            testsFailed++; $display("[TB] FAIL seq_read%0d got=%h/%b want=%h/00", i, d, resp, 32'(i + 1));
         end
      end
      testsRun++;
      if (ctrl !== 32'd1 || ftwMark !== 32'd2 || ftwSpace !== 32'd3 || aux !== 32'd4) begin
         testsFailed++; $display("[TB] FAIL seq_outputs got=%h %h %h %h want=1 2 3 4", ctrl, ftwMark, ftwSpace, aux);
      end
   endtask

   task automatic test_w_before_aw();
      wData = 32'hDEADBEEF; wStrb = 4'hF; wValid = 1'b1;
      stepClk();
      wValid = 1'b0;
      testsRun++;
      if (wReady !== 1'b0 || bValid !== 1'b0) begin
         testsFailed++; $display("[TB] FAIL wfirst_hold got wready=%b bvalid=%b want 0 0", wReady, bValid);
      end
      stepClk();
      stepClk();
      awAddr = 4'h4; awValid = 1'b1;
      testsRun++;
      if (bValid !== 1'b0 || awReady !== 1'b1) begin
         testsFailed++; $display("[TB] FAIL wfirst_wait got bvalid=%b awready=%b want 0 1", bValid, awReady);
      end
      stepClk();
      awValid = 1'b0;
      testsRun++;
      if (bValid !== 1'b1 || ftwMark !== 32'hDEADBEEF || wrStb !== 4'b0010) begin
         testsFailed++; $display("[TB] FAIL wfirst_commit got bvalid=%b mark=%h stb=%b want 1 deadbeef 0010", bValid, ftwMark, wrStb);
      end
      stepClk();
      testsRun++;
      if (wrStb !== 4'b0000 || bValid !== 1'b1) begin
         testsFailed++; $display("[TB] FAIL wfirst_stb_pulse got stb=%b bvalid=%b want 0000 1", wrStb, bValid);
      end
      bReady = 1'b1;
      stepClk();
      bReady = 1'b0;
      testsRun++;
      if (bValid !== 1'b0 || awReady !== 1'b1 || wReady !== 1'b1) begin
         testsFailed++; $display("[TB] FAIL wfirst_bdone got bvalid=%b aw=%b w=%b want 0 1 1", bValid, awReady, wReady);
      end
   endtask

   task automatic test_strobe();
      logic [1:0] resp;
      logic [3:0] stb;
      doWrite(4'h8, 32'hFFFFFFFF, 4'hF, resp, stb);
      doWrite(4'h8, 32'h00000000, 4'b0101, resp, stb);
      testsRun++;
      if (ftwSpace !== 32'hFF00FF00) begin
         testsFailed++; $display("[TB] FAIL strobe_bytes got=%h want=ff00ff00", ftwSpace);
      end
      doWrite(4'h8, 32'h12345678, 4'b0000, resp, stb);
      testsRun++;
      if (ftwSpace !== 32'hFF00FF00 || stb !== 4'b0100 || resp !== 2'b00) begin
         testsFailed++; $display("[TB] FAIL strobe_zero got=%h stb=%b resp=%b want ff00ff00 0100 00", ftwSpace, stb, resp);
      end
   endtask

   task automatic test_bready_stall();
      awAddr = 4'hC; wData = 32'hA5A5A5A5; wStrb = 4'hF;
      awValid = 1'b1; wValid = 1'b1;
      stepClk();
      testsRun++;
      if (bValid !== 1'b1 || aux !== 32'hA5A5A5A5) begin
         testsFailed++; $display("[TB] FAIL stall_first got bvalid=%b aux=%h want 1 a5a5a5a5", bValid, aux);
      end
      awAddr = 4'h0; wData = 32'h00000077;
      for (int i = 0; i < 10; i++) begin
         testsRun++;
         if (bValid !== 1'b1 || bResp !== 2'b00 || awReady !== 1'b0 || wReady !== 1'b0 || ctrl !== 32'd1) begin
            testsFailed++;
            $display("[TB] FAIL stall_cycle%0d got bv=%b br=%b aw=%b w=%b ctrl=%h want 1 00 0 0 1", i, bValid, bResp, awReady, wReady, ctrl);
         end
         stepClk();
      end
      bReady = 1'b1;
      stepClk();
      testsRun++;
      if (bValid !== 1'b0 || awReady !== 1'b1 || wReady !== 1'b1) begin
         testsFailed++; $display("[TB] FAIL stall_release got bv=%b aw=%b w=%b want 0 1 1", bValid, awReady, wReady);
      end
      stepClk();
      awValid = 1'b0; wValid = 1'b0;
      testsRun++;
      if (bValid !== 1'b1 || ctrl !== 32'h77) begin
         testsFailed++; $display("[TB] FAIL stall_second got bv=%b ctrl=%h want 1 77", bValid, ctrl);
      end
      stepClk();
      bReady = 1'b0;
   endtask

   task automatic test_unaligned();
      logic [1:0]  resp;
      logic [3:0]  stb;
      logic [31:0] d;
      doWrite(4'h5, 32'h11223344, 4'hF, resp, stb);
      testsRun++;
      if (ftwMark !== 32'h11223344 || stb !== 4'b0010) begin
         testsFailed++; $display("[TB] FAIL unaligned_write got=%h stb=%b want 11223344 0010", ftwMark, stb);
      end
      doRead(4'hB, d, resp);
      testsRun++;
      if (d !== 32'hFF00FF00 || resp !== 2'b00) begin
         testsFailed++; $display("[TB] FAIL unaligned_read got=%h/%b want ff00ff00/00", d, resp);
      end
   endtask

   task automatic test_collision();
      logic [1:0]  resp;
      logic [3:0]  stb;
      logic [31:0] d;
      doWrite(4'h0, 32'h5, 4'hF, resp, stb);
      awAddr = 4'h0; wData = 32'h9; wStrb = 4'hF; awValid = 1'b1; wValid = 1'b1;
      arAddr = 4'h0; arValid = 1'b1;
      stepClk();
      awValid = 1'b0; wValid = 1'b0; arValid = 1'b0;
      testsRun++;
      if (rValid !== 1'b1 || rData !== 32'h5 || ctrl !== 32'h9) begin
         testsFailed++; $display("[TB] FAIL collision got rv=%b rdata=%h ctrl=%h want 1 5 9", rValid, rData, ctrl);
      end
      bReady = 1'b1; rReady = 1'b1;
      stepClk();
      bReady = 1'b0; rReady = 1'b0;
      doRead(4'h0, d, resp);
      testsRun++;
      if (d !== 32'h9) begin
         testsFailed++; $display("[TB] FAIL collision_after got=%h want 9", d);
      end
   endtask

   task automatic test_reset_mid();
      awAddr = 4'h8; wData = 32'hCAFE0001; wStrb = 4'hF; awValid = 1'b1; wValid = 1'b1;
      arAddr = 4'h4; arValid = 1'b1;
      stepClk();
      awValid = 1'b0; wValid = 1'b0; arValid = 1'b0;
      testsRun++;
      if (rValid !== 1'b1 || bValid !== 1'b1 || rData !== 32'h11223344) begin
         testsFailed++; $display("[TB] FAIL midreset_setup got rv=%b bv=%b rdata=%h want 1 1 11223344", rValid, bValid, rData);
      end
      #2;
      rstN = 1'b0;
      #1;
      testsRun++;
      if ({rValid, bValid, awReady, wReady, arReady} !== 5'b0 || rData !== 32'h0) begin
         testsFailed++; $display("[TB] FAIL midreset_hs got=%b rdata=%h want 00000 0", {rValid, bValid, awReady, wReady, arReady}, rData);
      end
      testsRun++;
      if ({ctrl, ftwMark, ftwSpace, aux} !== 128'h0 || wrStb !== 4'b0) begin
         testsFailed++; $display("[TB] FAIL midreset_regs got=%h stb=%b want 0", {ctrl, ftwMark, ftwSpace, aux}, wrStb);
      end
      @(negedge clk);
      rstN = 1'b1;
      stepClk();
      testsRun++;
      if ({awReady, wReady, arReady, bValid, rValid} !== 5'b11100) begin
         testsFailed++; $display("[TB] FAIL midreset_recover got=%b want 11100", {awReady, wReady, arReady, bValid, rValid});
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_w_before_aw();
      test_strobe();
      test_bready_stall();
      test_unaligned();
      test_collision();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
